// File: rtl/iec_bus_resolver.sv
// IEC bus resolver: synchronises and filters the ATN/CLK/DATA pins and wired-ANDs them with NDEV device pulls.
// Define IEC_ATN_WATCHDOG_EN to build the ATN acknowledge watchdog that drives no_dev.

module iec_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);
  localparam int CW = $clog2(FILT + 1);

  logic [SYNC_STAGES-1:0] sr;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = sr[SYNC_STAGES-1];

  // Accept on the FILT-th consecutive differing sample, so a clean step lands after SYNC_STAGES+FILT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '1;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], pin};
      if (sync != level) begin
        if (cnt == CW'(FILT - 1)) begin
          level <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module iec_bus_resolver #(
  parameter int NDEV        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 4,
  parameter int ATN_TMO     = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NDEV-1:0] dev_atn_o,
  input  logic [NDEV-1:0] dev_clk_o,
  input  logic [NDEV-1:0] dev_data_o,
  input  logic            iec_atn_i,
  input  logic            iec_clk_i,
  input  logic            iec_data_i,
  output logic            iec_atn_o,
  output logic            iec_clk_o,
  output logic            iec_data_o,
  output logic            bus_atn,
  output logic            bus_clk,
  output logic            bus_data,
  output logic            atn_fall,
  output logic            no_dev
);
  // Line order in the packed vectors: [2]=ATN, [1]=CLK, [0]=DATA.
  logic [2:0] pin_raw, dev_and, f, drv_q, bus_q;
  logic       atn_q;

  assign pin_raw = {iec_atn_i, iec_clk_i, iec_data_i};
  assign dev_and = {&dev_atn_o, &dev_clk_o, &dev_data_o};

  for (genvar g = 0; g < 3; g++) begin : g_line
    iec_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt (
      .clk   (clk),
      .reset (reset),
      .pin   (pin_raw[g]),
      .level (f[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drv_q    <= 3'b111;
      bus_q    <= 3'b111;
      atn_q    <= 1'b1;
      atn_fall <= 1'b0;
    end else begin
      drv_q    <= dev_and;
      bus_q    <= f & dev_and;
      atn_q    <= bus_q[2];
      atn_fall <= atn_q & ~bus_q[2];
    end
  end

  assign {iec_atn_o, iec_clk_o, iec_data_o} = drv_q;
  assign {bus_atn, bus_clk, bus_data}       = bus_q;

`ifdef IEC_ATN_WATCHDOG_EN
  localparam int CW = $clog2(ATN_TMO + 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ACKED   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] tmo;
  logic          fall_cond;
  logic          no_dev_q;

  // Same condition that sets atn_fall next edge; loading here keeps no_dev exactly ATN_TMO cycles after atn_fall.
  assign fall_cond = atn_q & ~bus_q[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tmo      <= '0;
      no_dev_q <= 1'b0;
    end else begin
      no_dev_q <= 1'b0;
      case (state)
        S_IDLE: if (fall_cond) begin
          tmo   <= CW'(ATN_TMO - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tmo != '0) tmo <= tmo - CW'(1);
          if (bus_q[2])        state <= S_IDLE;
          else if (!bus_q[0])  state <= S_ACKED;
          else if (tmo == '0) begin
            no_dev_q <= 1'b1;
            state    <= S_EXPIRED;
          end
        end
        S_ACKED, S_EXPIRED: if (bus_q[2]) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign no_dev = no_dev_q;
`else
  assign no_dev = 1'b0;
`endif
endmodule

// File: tb/tb_iec_bus_resolver.sv
// Randomised bench for iec_bus_resolver against a history-based reference model of pin filtering and ATN watchdog.
module tb_iec_bus_resolver;
  localparam int NDEV = 2, SS = 2, FILT = 4, TMO = 20, MAXC = 8192;
`ifdef IEC_ATN_WATCHDOG_EN
  localparam int WD = 1;
`else
  localparam int WD = 0;
`endif

  logic            clk = 1'b0, reset = 1'b1;
  logic [NDEV-1:0] dev_atn_o = '1, dev_clk_o = '1, dev_data_o = '1;
  logic            iec_atn_i = 1'b1, iec_clk_i = 1'b1, iec_data_i = 1'b1;
  logic            iec_atn_o, iec_clk_o, iec_data_o, bus_atn, bus_clk, bus_data, atn_fall, no_dev;

  iec_bus_resolver #(.NDEV(NDEV), .SYNC_STAGES(SS), .FILT(FILT), .ATN_TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .dev_atn_o(dev_atn_o), .dev_clk_o(dev_clk_o), .dev_data_o(dev_data_o),
    .iec_atn_i(iec_atn_i), .iec_clk_i(iec_clk_i), .iec_data_i(iec_data_i),
    .iec_atn_o(iec_atn_o), .iec_clk_o(iec_clk_o), .iec_data_o(iec_data_o),
    .bus_atn(bus_atn), .bus_clk(bus_clk), .bus_data(bus_data),
    .atn_fall(atn_fall), .no_dev(no_dev)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, nd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-cycle histories, rules stated over windows of past samples.
  int       k = 0, last_rst = 0;
  bit [2:0] pin_h [MAXC];
  bit [2:0] bus_h [MAXC];
  bit       fall_h[MAXC];
  bit [2:0] f_m = 3'b111, iec_exp = 3'b111, bus_exp = 3'b111;
  bit       fall_exp = 1'b0, nodev_exp = 1'b0;

  function automatic bit pin_at(int i, int l);
    if (i <= last_rst) return 1'b1;
    return pin_h[i % MAXC][l];
  endfunction

  function automatic bit bus_at(int i, int l);
    if (i <= last_rst) return 1'b1;
    return bus_h[i % MAXC][l];
  endfunction

  always @(posedge clk) begin : model
    bit [2:0] dand;
    bit       all_diff;
    k++;
    dand = {&dev_atn_o, &dev_clk_o, &dev_data_o};
    if (reset) begin
      last_rst  = k;
      f_m       = 3'b111;
      iec_exp   = 3'b111;
      bus_exp   = 3'b111;
      fall_exp  = 1'b0;
      nodev_exp = 1'b0;
    end else begin
      pin_h[k % MAXC] = {iec_atn_i, iec_clk_i, iec_data_i};
      iec_exp = dand;
      bus_exp = f_m & dand;
      // A line's accepted level flips once its last FILT synchronised samples all disagree with it.
      for (int l = 0; l < 3; l++) begin
        all_diff = 1'b1;
        for (int j = 0; j < FILT; j++)
          if (pin_at(k - SS - j, l) == f_m[l]) all_diff = 1'b0;
        if (all_diff) f_m[l] = ~f_m[l];
      end
      fall_exp  = bus_at(k - 2, 2) & ~bus_at(k - 1, 2);
      nodev_exp = 1'b0;
      if (WD == 1) begin
        int a;
        bit ok;
        // Timeout TMO cycles after a fall when DATA stayed high and ATN stayed low the whole time.
        a = k - TMO;
        if (a > last_rst && fall_h[a % MAXC]) begin
          ok = 1'b1;
          for (int c = a; c < k; c++)
            if (bus_h[c % MAXC][0] != 1'b1 || bus_h[c % MAXC][2] != 1'b0) ok = 1'b0;
          nodev_exp = ok;
        end
      end
    end
    bus_h[k % MAXC]  = bus_exp;
    fall_h[k % MAXC] = fall_exp;
  end

  always @(negedge clk) begin
    if (k > 0) begin
      chk("iec_o",    {29'd0, iec_atn_o, iec_clk_o, iec_data_o}, {29'd0, iec_exp});
      chk("bus",      {29'd0, bus_atn, bus_clk, bus_data},       {29'd0, bus_exp});
      chk("atn_fall", {31'd0, atn_fall},                         {31'd0, fall_exp});
      chk("no_dev",   {31'd0, no_dev},                           {31'd0, nodev_exp});
      nd_cnt += int'(no_dev);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic idle();
    dev_atn_o = '1; dev_clk_o = '1; dev_data_o = '1;
    iec_atn_i = 1'b1; iec_clk_i = 1'b1; iec_data_i = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int          nd0, d;
    reset = 1'b1;
    repeat (3) begin
      r = $urandom;
      dev_atn_o = r[1:0]; dev_clk_o = r[3:2]; dev_data_o = r[5:4];
      iec_atn_i = r[6]; iec_clk_i = r[7]; iec_data_i = r[8];
      @(negedge clk);
    end
    reset = 1'b0;
    idle();
    step(1);
    chk("rst_bus", {29'd0, bus_atn, bus_clk, bus_data}, 32'd7);
    chk("rst_no_dev", {31'd0, no_dev}, 32'd0);
    step(10);

    dev_clk_o = 2'b10; step(3);
    chk("pull_bus_clk", {31'd0, bus_clk}, 32'd0);
    dev_clk_o = 2'b11; step(3);

    iec_data_i = 1'b0; step(3); iec_data_i = 1'b1; step(12);
    iec_data_i = 1'b0; step(10); iec_data_i = 1'b1; step(12);

    repeat (250) begin
      r = $urandom;
      iec_atn_i = r[0]; iec_clk_i = r[1]; iec_data_i = r[2];
      if (r[4:3] == 2'b00) begin
        dev_atn_o = r[6:5]; dev_clk_o = r[8:7]; dev_data_o = r[10:9];
      end else begin
        dev_atn_o = '1; dev_clk_o = '1; dev_data_o = '1;
      end
      step($urandom_range(1, 7));
    end
    idle(); step(20);

    nd0 = nd_cnt;
    dev_atn_o[0] = 1'b0; step(7);
    dev_data_o[1] = 1'b0; step(TMO + 10);
    chk("ack_pulses", nd_cnt - nd0, 0);
    idle(); step(10);

    nd0 = nd_cnt;
    dev_atn_o[0] = 1'b0; step(TMO + 10);
    chk("tmo_pulses", nd_cnt - nd0, WD);
    dev_data_o[1] = 1'b0; step(TMO + 5);
    chk("tmo_no_repulse", nd_cnt - nd0, WD);
    idle(); step(10);

    for (int dd = TMO - 3; dd <= TMO + 3; dd++) begin
      dev_atn_o[0] = 1'b0; step(dd);
      dev_data_o[1] = 1'b0; step(10);
      idle(); step(10);
    end

    dev_atn_o[0] = 1'b0; step(8);
    nd0 = nd_cnt;
    reset = 1'b1; idle(); step(2);
    reset = 1'b0; step(TMO + 10);
    chk("rst_abort", nd_cnt - nd0, 0);

    repeat (25) begin
      r = $urandom;
      d = $urandom_range(1, TMO + 5);
      dev_atn_o[0] = 1'b0; step(d);
      if (r[0]) dev_data_o[1] = 1'b0;
      if (r[1]) iec_atn_i = 1'b0;
      step($urandom_range(1, 12));
      idle(); step($urandom_range(1, 15));
    end
    step(10);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iec_bus_resolver.md
# iec_bus_resolver

Parametrised IEC serial-bus resolver between NDEV internal bus masters and the external IEC pins of the board. It synchronises and glitch-filters the ATN/CLK/DATA pin inputs. It wired-ANDs them with all internal open-collector outputs and drives the pins from the internal devices. It also flags ATN sequences that no device acknowledges. It generalises the fixed single-device tie-off at the top level to N devices plus a physical port.

## Interface
Parameters:
- NDEV, 2: number of internal devices (≥1)
- SYNC_STAGES, 2: pin-input synchroniser depth (≥2)
- FILT, 4: consecutive stable cycles required to accept a pin change (≥1)
- ATN_TMO, 1000: cycles allowed for DATA acknowledge after ATN falls (≥1)

Ports:
- clk  in  1  system clock; the block uses this single clock
- reset  in  1  synchronous, active-high reset
- dev_atn_o  in  NDEV  per-device ATN output; 1 = released, 0 = pull low
- dev_clk_o  in  NDEV  per-device CLK output; same encoding
- dev_data_o  in  NDEV  per-device DATA output; same encoding
- iec_atn_i, iec_clk_i, iec_data_i  in  1 each  raw asynchronous pin levels
- iec_atn_o, iec_clk_o, iec_data_o  out  1 each  pin drive; 0 = pull low
- bus_atn, bus_clk, bus_data  out  1 each  resolved bus level, fanned out to all devices
- atn_fall  out  1  one-cycle pulse on each bus_atn 1→0 transition
- no_dev  out  1  one-cycle pulse on acknowledge timeout

## Operation
- Pin path, per line: SYNC_STAGES flops, then a filter.
  - Filter holds an accepted level `f`.
  - A counter of width $clog2(FILT+1) increments while the synchronised input differs from `f` and clears when they match.
  - When the count reaches FILT, `f` takes the new value and the counter clears.
- Drive path: iec_x_o is registered as the AND of dev_x_o[NDEV-1:0].
- Resolution: bus_x is registered as the AND of (`f` for that line) and all dev_x_o bits.
- Internal devices see their own pulls without filter delay. External pulls are seen only after filtering.
- atn_fall: registered edge detect on bus_atn, high for exactly one cycle.
- Acknowledge watchdog FSM, present only with the macro below. States:
  - IDLE: on atn_fall, load the counter with ATN_TMO-1 and go to WAIT.
  - WAIT: decrement each cycle.
    - If bus_data==0, go to ACKED.
    - Else if the counter is 0, pulse no_dev and go to EXPIRED.
    - If bus_atn==1, go to IDLE with no pulse.
  - ACKED / EXPIRED: go to IDLE when bus_atn==1.
- WAIT boundary cases:
  - bus_data==0 in the same cycle the counter hits 0: ACKED wins and there is no pulse.
  - bus_atn rising in the same cycle as an ack or expiry: IDLE wins.
  - A new atn_fall can only occur after IDLE is re-entered. The counter never wraps; it saturates at 0.
- reset mid-operation: the FSM returns to IDLE, the counters clear, and any pending no_dev pulse is suppressed.

## Timing
- Reset values:
  - all iec_x_o, bus_x and filter levels `f` = 1
  - synchroniser flops = 1
  - atn_fall = 0, no_dev = 0, FSM = IDLE
- dev_x_o → iec_x_o: 1 cycle.
- dev_x_o → bus_x: 1 cycle.
- iec_x_i step → bus_x: SYNC_STAGES + FILT + 1 cycles for a clean step.
- Glitch rejection: a pin pulse shorter than FILT cycles after synchronisation never reaches bus_x.
- atn_fall: asserted the cycle after bus_atn first reads 0.
- no_dev: asserted ATN_TMO cycles after atn_fall, provided bus_data stays 1 and bus_atn stays 0.
- The FSM samples bus_* (registered) only. There is no combinational path from iec_x_i to any output.

## Configuration
- IEC_ATN_WATCHDOG_EN defined:
  - FSM and timeout counter are built.
  - no_dev behaves as specified.
- IEC_ATN_WATCHDOG_EN undefined:
  - FSM and counter are omitted.
  - no_dev is tied to 0.
  - All other behaviour, including atn_fall, is unchanged.

## Test plan
- Reset: hold reset 3 cycles with random inputs → all iec_x_o = 1, bus_x = 1, atn_fall = 0 and no_dev = 0 on the cycle after reset deasserts.
- Internal pull, NDEV=2, pins idle 1: dev_clk_o = 2'b10 → bus_clk = 0 and iec_clk_o = 0 exactly 1 cycle later. Release to 2'b11 → both return to 1 after 1 cycle.
- Filter, FILT=4, SYNC_STAGES=2:
  - iec_data_i low for 3 cycles → bus_data stays 1.
  - iec_data_i low for 10 cycles → bus_data = 0 on cycle 7 after the edge.
- Acknowledge, macro on, ATN_TMO=20: dev_atn_o[0] = 0, then dev_data_o[1] = 0 five cycles after atn_fall → one atn_fall pulse, no_dev never asserted.
- Timeout, macro on, ATN_TMO=20, ATN low with DATA held 1 → single no_dev pulse 20 cycles after atn_fall. Pulling DATA low afterwards does not re-pulse. Releasing ATN returns the FSM to IDLE.
- Tie and abort:
  - DATA falls exactly on the expiry cycle → no no_dev.
  - reset asserted mid-WAIT → no_dev stays 0.
  - Macro off → no_dev constantly 0 across all scenarios.
